// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: ISA opcodes, NOP word and instruction field helpers shared by fetch and decode
package fetch_stage_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    function automatic logic [5:0] opcode(input logic [31:0] w);
        return w[31:26];
    endfunction

    function automatic logic [4:0] rs(input logic [31:0] w);
        return w[25:21];
    endfunction

    function automatic logic [4:0] rt(input logic [31:0] w);
        return w[20:16];
    endfunction

    function automatic logic [25:0] imm26(input logic [31:0] w);
        return w[25:0];
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem, hazard, redirect and IF/ID signals of the fetch stage
interface fetch_stage_if #(parameter int CNT_W = 16);
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             br_taken;
    logic [31:0]      br_target;
    logic [31:0]      ir;
    logic [31:0]      pc_plus4;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output imem_addr, ir, pc_plus4, bubble, stall_cnt, flush_cnt,
        input  imem_rdata, ex_memread, ex_rt, br_taken, br_target
    );

    modport slave (
        input  imem_addr, ir, pc_plus4, bubble, stall_cnt, flush_cnt,
        output imem_rdata, ex_memread, ex_rt, br_taken, br_target
    );
endinterface

// File: rtl/fetch_stage_hazard_detect.sv
// hazard_detect: load-use hazard between the lw in EX and the instruction in ID
module hazard_detect
    import fetch_stage_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    output logic        haz
);
    logic [5:0] op;
    logic       rt_used;

    assign op      = opcode(ir);
    // lw's rt is a destination, so only these opcodes read rt
    assign rt_used = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    assign haz     = ex_memread && (ex_rt != 5'd0) && (ir != NOP) && (op != OP_J) &&
                     ((ex_rt == rs(ir)) || (rt_used && (ex_rt == rt(ir))));
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC and IF/ID register with load-use stall, branch/jump redirect and
// saturating stall/flush counters
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    logic [31:0]      pc, ir, pc_plus4, pc_next4, jump_target;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             haz, is_j;

    hazard_detect u_hazard (
        .ir         (ir),
        .ex_memread (bus.ex_memread),
        .ex_rt      (bus.ex_rt),
        .haz        (haz)
    );

    assign pc_next4      = pc + 32'd4;
    assign is_j          = opcode(ir) == OP_J;
    assign jump_target   = {pc_plus4[31:28], imm26(ir), 2'b00};
    assign bus.imem_addr = pc;
    assign bus.ir        = ir;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.bubble    = haz & ~bus.br_taken;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            ir        <= NOP;
            pc_plus4  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (bus.br_taken) begin
            pc        <= bus.br_target;
            ir        <= NOP;
            pc_plus4  <= '0;
            flush_cnt <= &flush_cnt ? flush_cnt : flush_cnt + 1'b1;
        end else if (haz) begin
            stall_cnt <= &stall_cnt ? stall_cnt : stall_cnt + 1'b1;
        end else if (is_j) begin
            // the word fetched alongside the jump is on the wrong path
            pc        <= jump_target;
            ir        <= NOP;
            pc_plus4  <= '0;
            flush_cnt <= &flush_cnt ? flush_cnt : flush_cnt + 1'b1;
        end else begin
            pc        <= pc_next4;
            ir        <= bus.imem_rdata;
            pc_plus4  <= pc_next4;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed tests of fetch_stage with a 4-bit counter width so saturation is reachable
module tb_fetch_stage;
    localparam logic [31:0] ADD_T1 = 32'h010A_4820;
    localparam logic [31:0] LW_T0  = 32'h8D28_0000;
    localparam logic [31:0] J_40   = 32'h0800_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        force_en = 1'b0;
    logic [31:0] force_word = '0;
    int          checks = 0;
    int          errors = 0;

    fetch_stage_if #(.CNT_W(4)) bus ();

    fetch_stage #(.RESET_PC(32'h0), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // imem returns an addi whose low 26 bits are the address, unless a word is forced
    assign bus.imem_rdata = force_en ? force_word : {6'b001000, bus.imem_addr[25:0]};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        bus.ex_memread = 1'b0;
        bus.ex_rt = 5'd0;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        #2;
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", bus.imem_addr); end
        checks++; if (bus.ir !== 32'h0) begin errors++; $display("FAIL rst_ir got %h exp 0", bus.ir); end
        checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pp4 got %h exp 0", bus.pc_plus4); end
        checks++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt); end
        checks++; if (bus.bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble got %b exp 0", bus.bubble); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (bus.imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, bus.imem_addr, 32'(4 * i)); end
            checks++; if (bus.ir !== (32'h2000_0000 + 32'(4 * (i - 1)))) begin errors++; $display("FAIL seq_ir%0d got %h exp %h", i, bus.ir, 32'h2000_0000 + 32'(4 * (i - 1))); end
            checks++; if (bus.pc_plus4 !== 32'(4 * i)) begin errors++; $display("FAIL seq_pp4%0d got %h exp %h", i, bus.pc_plus4, 32'(4 * i)); end
        end
    endtask

    task automatic test_stall();
        force_en = 1'b1; force_word = ADD_T1;
        step();
        force_en = 1'b0;
        chk32("stall_pre_ir", bus.ir, ADD_T1);
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd8;
        #1;
        checks++; if (bus.bubble !== 1'b1) begin errors++; $display("FAIL stall_bubble got %b exp 1", bus.bubble); end
        step();
        chk32("stall_pc_hold", bus.imem_addr, 32'h10);
        chk32("stall_ir_hold", bus.ir, ADD_T1);
        checks++; if (bus.stall_cnt !== 4'd1) begin errors++; $display("FAIL stall_cnt got %0d exp 1", bus.stall_cnt); end
        bus.ex_memread = 1'b0;
        #1;
        checks++; if (bus.bubble !== 1'b0) begin errors++; $display("FAIL stall_release_bubble got %b exp 0", bus.bubble); end
        step();
        chk32("stall_resume_pc", bus.imem_addr, 32'h14);
        chk32("stall_resume_ir", bus.ir, 32'h2000_0010);
        // ex_rt of $zero never stalls
        force_en = 1'b1; force_word = ADD_T1;
        step();
        force_en = 1'b0;
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd0;
        #1;
        checks++; if (bus.bubble !== 1'b0) begin errors++; $display("FAIL zero_rt_bubble got %b exp 0", bus.bubble); end
        step();
        chk32("zero_rt_pc", bus.imem_addr, 32'h1C);
        // lw $8,0($9): rt is a destination, so ex_rt=8 must not stall
        force_en = 1'b1; force_word = LW_T0;
        step();
        force_en = 1'b0;
        bus.ex_rt = 5'd8;
        #1;
        checks++; if (bus.bubble !== 1'b0) begin errors++; $display("FAIL lw_rt_bubble got %b exp 0", bus.bubble); end
        step();
        chk32("lw_rt_pc", bus.imem_addr, 32'h24);
        checks++; if (bus.stall_cnt !== 4'd1) begin errors++; $display("FAIL nostall_cnt got %0d exp 1", bus.stall_cnt); end
        bus.ex_memread = 1'b0;
    endtask

    task automatic test_jump();
        bus.br_taken = 1'b1; bus.br_target = 32'h4;
        step();
        bus.br_taken = 1'b0;
        chk32("br4_pc", bus.imem_addr, 32'h4);
        checks++; if (bus.flush_cnt !== 4'd1) begin errors++; $display("FAIL br4_flush got %0d exp 1", bus.flush_cnt); end
        force_en = 1'b1; force_word = J_40;
        step();
        force_en = 1'b0;
        chk32("j_ir", bus.ir, J_40);
        chk32("j_pp4", bus.pc_plus4, 32'h8);
        step();
        chk32("j_pc", bus.imem_addr, 32'h40);
        chk32("j_ir_squash", bus.ir, 32'h0);
        chk32("j_pp4_clear", bus.pc_plus4, 32'h0);
        checks++; if (bus.flush_cnt !== 4'd2) begin errors++; $display("FAIL j_flush got %0d exp 2", bus.flush_cnt); end
        step();
        chk32("j_after_pc", bus.imem_addr, 32'h44);
        chk32("j_after_ir", bus.ir, 32'h2000_0040);
    endtask

    task automatic test_branch_over_haz();
        force_en = 1'b1; force_word = ADD_T1;
        step();
        force_en = 1'b0;
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd8;
        bus.br_taken = 1'b1; bus.br_target = 32'h100;
        #1;
        checks++; if (bus.bubble !== 1'b0) begin errors++; $display("FAIL brhaz_bubble got %b exp 0", bus.bubble); end
        step();
        bus.br_taken = 1'b0; bus.ex_memread = 1'b0;
        chk32("brhaz_pc", bus.imem_addr, 32'h100);
        chk32("brhaz_ir", bus.ir, 32'h0);
        checks++; if (bus.flush_cnt !== 4'd3 || bus.stall_cnt !== 4'd1) begin errors++; $display("FAIL brhaz_cnt got %0d/%0d exp 3/1", bus.flush_cnt, bus.stall_cnt); end
    endtask

    task automatic test_wrap();
        bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFC;
        step();
        bus.br_taken = 1'b0;
        chk32("wrap_pre_pc", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk32("wrap_pc", bus.imem_addr, 32'h0);
        chk32("wrap_pp4", bus.pc_plus4, 32'h0);
        chk32("wrap_ir", bus.ir, 32'h23FF_FFFC);
    endtask

    task automatic test_saturate();
        force_en = 1'b1; force_word = ADD_T1;
        step();
        force_en = 1'b0;
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd8;
        repeat (20) step();
        checks++; if (bus.stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_stall got %0d exp 15", bus.stall_cnt); end
        chk32("sat_pc_hold", bus.imem_addr, 32'h4);
        checks++; if (bus.bubble !== 1'b1) begin errors++; $display("FAIL sat_bubble got %b exp 1", bus.bubble); end
        bus.br_taken = 1'b1; bus.br_target = 32'h200;
        repeat (14) step();
        bus.br_taken = 1'b0;
        checks++; if (bus.flush_cnt !== 4'hF || bus.stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_flush got %0d/%0d exp 15/15", bus.flush_cnt, bus.stall_cnt); end
        chk32("sat_br_pc", bus.imem_addr, 32'h200);
    endtask

    task automatic test_reset_midstall();
        force_en = 1'b1; force_word = ADD_T1;
        step();
        force_en = 1'b0;
        repeat (2) step();
        chk32("mid_pc_hold", bus.imem_addr, 32'h204);
        #2 rst = 1'b1;
        #1;
        chk32("mid_rst_pc", bus.imem_addr, 32'h0);
        chk32("mid_rst_ir", bus.ir, 32'h0);
        chk32("mid_rst_pp4", bus.pc_plus4, 32'h0);
        checks++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt); end
        checks++; if (bus.bubble !== 1'b0) begin errors++; $display("FAIL mid_rst_bubble got %b exp 0", bus.bubble); end
        @(negedge clk);
        rst = 1'b0;
        step();
        chk32("mid_restart_pc", bus.imem_addr, 32'h4);
        chk32("mid_restart_ir", bus.ir, 32'h2000_0000);
        bus.ex_memread = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_jump();
        test_branch_over_haz();
        test_wrap();
        test_saturate();
        test_reset_midstall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
